// File: rtl/uart_receive.sv
// 8N1 UART receiver.
// The RX pin is brought into the CLK domain by a two-flop synchronizer. A
// falling edge starts a frame. The baud counter restarts on every state
// change, so all sample points are measured from the detected start edge:
// the start bit is checked at mid-bit, and every later bit one full bit
// period after the previous sample. A good stop bit publishes the byte with
// a one-cycle VALID pulse. A low stop bit gives a one-cycle FERR pulse, and
// the receiver then waits for the line to return high, so a break cannot
// start a run of bogus frames.
//
// Handshake: VALID is a one-cycle strobe with no back-pressure. DATA changes
// only in the cycle VALID is high and then holds until the next good frame.
// FERR is a one-cycle strobe and is never high together with VALID.
// BDR (clocks per bit) must be at least 4.
module uart_receive #(
  parameter int SCYCLE   = 50_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY,
  output logic [2:0] dbg_state
);

  localparam int BDR  = SCYCLE / BAUDRATE;
  localparam int HALF = BDR / 2;
  localparam int CW   = $clog2(BDR + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BDR_M1  = CW'(BDR - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  logic          rx_meta_q, rxs_q;
  state_t        state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Two-flop synchronizer. It resets to idle-high so no start edge appears
  // when reset is released.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic. Every transition clears the baud counter, so the
  // counter always starts at zero in the first cycle of a state.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        bidx_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == HALF_M1) begin
          bcnt_d = '0;
          bidx_d = '0;
          // A line that is high again at mid-bit was only a glitch.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bcnt_q == BDR_M1) begin
          bcnt_d          = '0;
          shift_d[bidx_q] = rxs_q;
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bcnt_q == BDR_M1) begin
          bcnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAITHI;
          end
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
        end
      end
      S_WAITHI: begin
        bcnt_d = '0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // Drive the outputs from the registers.
  always_comb begin
    DATA      = data_q;
    VALID     = valid_q;
    FERR      = ferr_q;
    BUSY      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

endmodule
